// File: rtl/sound_event_scheduler.sv
// Tone sequencer for three game sound events: latches request pulses, plays
// one fixed-length tone at a time by fixed priority, then holds a silent gap.
module sound_event_scheduler #(
  parameter int DUR_CYCLES = 12_500_000,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       mute,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [23:0] DUR_M1 = 24'(DUR_CYCLES - 1);
  localparam logic [23:0] GAP_M1 = 24'(GAP_CYCLES - 1);

  // Isolates the lowest set bit: req[0] has the highest priority.
  function automatic logic [2:0] lowest_onehot(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  function automatic logic [1:0] sel_code(input logic [2:0] onehot);
    logic [1:0] code;
    case (onehot)
      3'b001:  code = 2'd1;
      3'b010:  code = 2'd2;
      3'b100:  code = 2'd3;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [23:0] r_cnt, w_cnt_nxt;
  logic        r_tone_en, w_tone_en_nxt;
  logic [1:0]  r_tone_sel, w_tone_sel_nxt;
  logic [2:0]  r_grant, w_grant_nxt;
  logic        r_busy, w_busy_nxt;
  logic [2:0]  r_pending, w_pending_nxt;
  logic [2:0]  w_req_all, w_winner;
  logic        w_launch;

  assign w_req_all     = r_pending | req;
  assign w_winner      = lowest_onehot(w_req_all);
  assign w_pending_nxt = w_req_all & ~(w_launch ? w_winner : 3'b000);
  assign w_busy_nxt    = (w_state_nxt != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_tone_en_nxt  = r_tone_en;
    w_tone_sel_nxt = r_tone_sel;
    w_grant_nxt    = 3'b000;
    w_launch       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // mute holds off launch while requests keep accumulating
        if (!mute && (w_req_all != 3'b000)) begin
          w_launch       = 1'b1;
          w_state_nxt    = S_PLAY;
          w_cnt_nxt      = DUR_M1;
          w_tone_en_nxt  = 1'b1;
          w_tone_sel_nxt = sel_code(w_winner);
          w_grant_nxt    = w_winner;
        end
      end
      S_PLAY: begin
        if (mute) begin
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = 24'd0;
          w_tone_en_nxt  = 1'b0;
          w_tone_sel_nxt = 2'd0;
        end else if (r_cnt == 24'd0) begin
          w_state_nxt    = S_GAP;
          w_cnt_nxt      = GAP_M1;
          w_tone_en_nxt  = 1'b0;
          w_tone_sel_nxt = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt - 24'd1;
        end
      end
      S_GAP: begin
        if (mute || (r_cnt == 24'd0)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 24'd0;
        end else begin
          w_cnt_nxt = r_cnt - 24'd1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_cnt_nxt      = 24'd0;
        w_tone_en_nxt  = 1'b0;
        w_tone_sel_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 24'd0;
      r_tone_en  <= 1'b0;
      r_tone_sel <= 2'd0;
      r_grant    <= 3'b000;
      r_busy     <= 1'b0;
      r_pending  <= 3'b000;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_tone_en  <= w_tone_en_nxt;
      r_tone_sel <= w_tone_sel_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_pending  <= w_pending_nxt;
    end
  end

  assign tone_en  = r_tone_en;
  assign tone_sel = r_tone_sel;
  assign grant    = r_grant;
  assign busy     = r_busy;
  assign pending  = r_pending;

endmodule
